// File: rtl/sw_cond.sv
// Push-button conditioner: per-channel synchroniser, debouncer and
// press/release/auto-repeat pulse generator for active-low raw buttons.
module sw_cond #(
  parameter int unsigned NUM_SW  = 3,
  parameter int unsigned DEB_CNT = 500000,
  parameter int unsigned RPT_DLY = 25000000,
  parameter int unsigned RPT_PER = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] i_sw_n,
  output logic [NUM_SW-1:0] o_level,
  output logic [NUM_SW-1:0] o_press,
  output logic [NUM_SW-1:0] o_release,
  output logic [NUM_SW-1:0] o_repeat,
  output logic [NUM_SW-1:0] o_evt
);

  typedef enum logic [1:0] {StIdle, StHeld, StRpt} state_e;

  localparam logic [31:0] DebLast    = 32'(DEB_CNT - 1);
  localparam logic [31:0] RptDlyLast = 32'(RPT_DLY - 1);
  localparam logic [31:0] RptPerLast = 32'(RPT_PER - 1);

  logic [NUM_SW-1:0] sync1_q, sync2_q, s_sync;

  // Synchroniser resets to "released" so a held button reads as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_sw_n;
      sync2_q <= sync1_q;
    end
  end

  assign s_sync = ~sync2_q;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    logic [31:0] deb_q, deb_d;
    logic [31:0] hold_q, hold_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        repeat_q, repeat_d;
    logic        rise, fall;
    state_e      state_q, state_d;

    always_comb begin
      level_d = level_q;
      deb_d   = '0;
      if (s_sync[g] != level_q) begin
        if (deb_q == DebLast) begin
          level_d = s_sync[g];
        end else begin
          deb_d = deb_q + 32'd1;
        end
      end
    end

    // Edges are taken from the next level so pulses line up with o_level.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            press_d = 1'b1;
            hold_d  = '0;
            state_d = StHeld;
          end
        end
        StHeld: begin
          if (fall) begin
            release_d = 1'b1;
            hold_d    = '0;
            state_d   = StIdle;
          end else if (hold_q == RptDlyLast) begin
            repeat_d = 1'b1;
            hold_d   = '0;
            state_d  = StRpt;
          end else begin
            hold_d = hold_q + 32'd1;
          end
        end
        StRpt: begin
          if (fall) begin
            release_d = 1'b1;
            hold_d    = '0;
            state_d   = StIdle;
          end else if (hold_q == RptPerLast) begin
            repeat_d = 1'b1;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + 32'd1;
          end
        end
        default: begin
          hold_d  = '0;
          state_d = StIdle;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_q     <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        state_q   <= StIdle;
      end else begin
        deb_q     <= deb_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
        state_q   <= state_d;
      end
    end

    assign o_level[g]   = level_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_repeat[g]  = repeat_q;
    assign o_evt[g]     = press_q | repeat_q;
  end

endmodule

// File: tb/tb_sw_cond.sv
// Bench for sw_cond: directed scenarios with fixed timing expectations plus a
// randomized phase compared every cycle against a history-window reference model.
module tb_sw_cond;

  localparam int unsigned NUM_SW  = 3;
  localparam int unsigned DEB_CNT = 4;
  localparam int unsigned RPT_DLY = 20;
  localparam int unsigned RPT_PER = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_SW-1:0] i_sw_n = '1;
  logic [NUM_SW-1:0] o_level, o_press, o_release, o_repeat, o_evt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  sw_cond #(
    .NUM_SW (NUM_SW),
    .DEB_CNT(DEB_CNT),
    .RPT_DLY(RPT_DLY),
    .RPT_PER(RPT_PER)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .i_sw_n   (i_sw_n),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_repeat (o_repeat),
    .o_evt    (o_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a level is accepted once the last DEB_CNT synchronised
  // samples (raw samples two edges old) agree; pulses follow from elapsed time.
  typedef struct packed {
    logic [DEB_CNT:0] hist;   // bit 0 = raw pressed sampled one edge ago
    logic             level;
    logic             press;
    logic             rel;
    logic             rpt;
    logic [31:0]      tp;     // cycle of the accepted press
  } ch_t;

  ch_t mdl [NUM_SW];

  function automatic ch_t step(input ch_t c, input logic pressed, input int unsigned now);
    ch_t         n;
    int unsigned e;
    n       = c;
    n.press = 1'b0;
    n.rel   = 1'b0;
    n.rpt   = 1'b0;
    if (c.hist[DEB_CNT:1] == '1 && !c.level) begin
      n.level = 1'b1;
      n.press = 1'b1;
      n.tp    = now;
    end else if (c.hist[DEB_CNT:1] == '0 && c.level) begin
      n.level = 1'b0;
      n.rel   = 1'b1;
    end else if (c.level) begin
      e = now - c.tp;
      if (e == RPT_DLY || (e > RPT_DLY && (e - RPT_DLY) % RPT_PER == 0)) n.rpt = 1'b1;
    end
    n.hist = {c.hist[DEB_CNT-1:0], pressed};
    return n;
  endfunction

  function automatic logic [5*NUM_SW-1:0] model_vec();
    logic [NUM_SW-1:0] l, p, r, t;
    for (int ch = 0; ch < NUM_SW; ch++) begin
      l[ch] = mdl[ch].level;
      p[ch] = mdl[ch].press;
      r[ch] = mdl[ch].rel;
      t[ch] = mdl[ch].rpt;
    end
    return {l, p, r, t, p | t};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    for (int ch = 0; ch < NUM_SW; ch++) begin
      if (rst) mdl[ch] <= '0;
      else     mdl[ch] <= step(mdl[ch], ~i_sw_n[ch], cyc);
    end
  end

  always @(posedge clk) begin
    #2;
    check("model", 32'({o_level, o_press, o_release, o_repeat, o_evt}), 32'(model_vec()));
  end

  int unsigned n_evt, n_rpt;
  int unsigned dur [NUM_SW];

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Clean press on channel 0, then release.
    i_sw_n[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #3;
      check("clean_lvl", 32'(o_level[0]), 32'(k >= 6));
      check("clean_prs", 32'(o_press[0]), 32'(k == 6));
      check("clean_rpt", 32'(o_repeat[0]), 0);
    end
    i_sw_n[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #3;
      check("clean_rel", 32'(o_release[0]), 32'(k == 6));
    end

    // Bounce on channel 1: low 3, high 2, low 3, then high.
    for (int k = 0; k < 20; k++) begin
      i_sw_n[1] = !(k < 3 || (k >= 5 && k < 8));
      @(posedge clk); #3;
      check("bounce", 32'({o_level[1], o_press[1], o_evt[1]}), 0);
    end

    // Auto-repeat on channel 2; release lands on the offset-60 repeat slot.
    n_evt = 0;
    n_rpt = 0;
    i_sw_n[2] = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk); #3;
      check("ar_prs", 32'(o_press[2]), 32'(k == 6));
      check("ar_rpt", 32'(o_repeat[2]), 32'(k >= 26 && k <= 61 && (k - 26) % 5 == 0));
      check("ar_rel", 32'(o_release[2]), 32'(k == 66));
      n_evt += 32'(o_evt[2]);
      n_rpt += 32'(o_repeat[2]);
      if (k == 60) i_sw_n[2] = 1'b1;
    end
    check("ar_evt_cnt", n_evt, 9);
    check("ar_rpt_cnt", n_rpt, 8);

    // Reset during RPT while channel 0 is held.
    i_sw_n[0] = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_async", 32'({o_level, o_press, o_release, o_repeat, o_evt}), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #3;
      check("rst_hold", 32'({o_level, o_press, o_release, o_repeat, o_evt}), 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #3;
      check("rst_prs", 32'(o_press[0]), 32'(k == 6));
      check("rst_lvl", 32'(o_level[0]), 32'(k >= 6));
    end
    i_sw_n[0] = 1'b1;
    repeat (10) @(posedge clk);
    #3;

    // All three pressed together; channel 1 released on a repeat slot.
    i_sw_n = '0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #3;
      check("cc_prs", 32'(o_press), (k == 6) ? 32'h7 : 32'h0);
      if (k == 36) begin
        check("cc_rel", 32'(o_release), 32'h2);
        check("cc_rpt36", 32'(o_repeat), 32'h5);
      end
      if (k == 41) check("cc_rpt41", 32'(o_repeat), 32'h5);
      if (k == 30) i_sw_n[1] = 1'b1;
    end
    i_sw_n = '1;
    repeat (10) @(posedge clk);
    #3;

    // Random phase: mix of glitches and long holds, with one mid-run reset.
    for (int ch = 0; ch < NUM_SW; ch++) dur[ch] = $urandom_range(1, 30);
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #3;
      for (int ch = 0; ch < NUM_SW; ch++) begin
        if (dur[ch] == 0) begin
          i_sw_n[ch] = ~i_sw_n[ch];
          dur[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB_CNT)
                                                 : $urandom_range(1, 60);
        end else begin
          dur[ch]--;
        end
      end
      if (i == 700) rst = 1'b1;
      if (i == 703) rst = 1'b0;
    end

    @(posedge clk); #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
